mp_bcast_fifo: RTL
==================

MP_BCAST_FIFO -- requirements
Module: mp_bcast_fifo

Interface
REQ-001 SHALL have parameter NrReadPort, default 2, number of independent read ports (>=1).
REQ-002 SHALL have parameter DataWidth, default 32, bits per entry.
REQ-003 SHALL have parameter Depth, default 8, entries, any value >=1, power of two not required.
REQ-004 SHALL have parameter AlmostFullThresh, default Depth-1, occupancy at or above which almost_full_o asserts.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk_i in 1, rising-edge clock; rst_i in 1, synchronous active-high reset.
REQ-006 SHALL have flush_i in 1, synchronous clear of all pointers and counts.
REQ-007 SHALL have data_i in DataWidth, write data; push_i in 1, write request.
REQ-008 SHALL have full_o out 1; almost_full_o out 1; usage_o out clog2(Depth+1), occupancy seen by the slowest enabled port.
REQ-009 SHALL have port_en_i in NrReadPort, per-port enable; a disabled port never holds up the writer.
REQ-010 SHALL have pop_i in NrReadPort, per-port read advance; empty_o out NrReadPort; data_o out NrReadPort x DataWidth, head entry per port.

Function
REQ-011 SHALL keep per-port read pointer rp[i] and count cnt[i], plus one write pointer wp; all pointers wrap from Depth-1 to 0.
REQ-012 SHALL NOT impose any ordering between read ports; any port may be ahead of any other.
REQ-013 SHALL compute usage_o as the maximum of cnt[i] over enabled ports, or 0 when no port is enabled.
REQ-014 SHALL drive full_o = (usage_o == Depth) and almost_full_o = (usage_o >= AlmostFullThresh), both purely from registered state.
REQ-015 SHALL accept a push when push_i && !full_o: write mem[wp], advance wp, increment cnt[i] of every enabled port.
REQ-016 SHALL ignore push_i while full_o is high, even when a pop occurs in the same cycle; no entry is overwritten.
REQ-017 SHALL accept a pop on port i when pop_i[i] && port_en_i[i] && !empty_o[i]: advance rp[i] and decrement cnt[i]; other pops are ignored.
REQ-018 SHALL, on simultaneous accepted push and pop on port i, leave cnt[i] unchanged and advance both pointers.
REQ-019 SHALL drive empty_o[i] = (cnt[i] == 0) || !port_en_i[i], subject to REQ-030, and data_o[i] = mem[rp[i]].
REQ-020 SHALL load rp[i] <= wp_next and cnt[i] <= 0 on every cycle that port_en_i[i] is low. On re-enable, the port sees only entries pushed from that cycle onward.
REQ-021 SHALL accept pushes and discard the data when no port is enabled; full_o stays 0 in that case.
REQ-022 SHALL give flush_i priority over push/pop in the same cycle; memory contents need not be cleared.
REQ-023 SHALL have a latency of 1 cycle, push to !empty_o, when REQ-030 is not active.

Reset
REQ-024 SHALL, on rst_i high at a rising clk_i edge, set wp, all rp[i] and all cnt[i] to 0, overriding every other input.
REQ-025 SHALL drive these output values after reset: full_o=0, almost_full_o=(AlmostFullThresh==0), usage_o=0, empty_o=all ones, data_o undefined (X-tolerant).
REQ-026 SHALL NOT reset the storage array.
REQ-027 SHALL, when reset is asserted mid-transfer, discard all in-flight entries; the first push after release lands in mem[0].

Configuration
REQ-028 SHALL support macro MP_BCAST_FIFO_FALL_THROUGH_EN.
REQ-029 SHALL, without the macro, behave as REQ-011 to REQ-023: data is visible only from the cycle after the push.
REQ-030 SHALL, with the macro, when cnt[i]==0, port_en_i[i]==1 and a push is accepted: drive empty_o[i]=0 and data_o[i]=data_i combinationally. A pop_i[i] in that cycle consumes the entry, so cnt[i] stays 0 and rp[i] advances with wp.

Verification
REQ-031 SHALL cover fill and drain: Depth=8, both ports enabled, 8 pushes 0..7 -> full_o=1, usage_o=8; a 9th push of 0xFF is dropped; port0 pops 8 -> reads 0..7, full_o stays 1 until port1 also pops.
REQ-032 SHALL cover the non-power-of-two wrap: Depth=5, 12 pushes interleaved with pops on both ports -> every port reads values in push order across the 4->0 wrap.
REQ-033 SHALL cover an out-of-order reader: port1 pops 3 of 4 while port0 pops 0 -> usage_o=4; port0 then pops 4 -> usage_o=1.
REQ-034 SHALL cover disable: port1 disabled with 6 entries pending, Depth=8 -> usage_o falls to port0's count; 2 more pushes are accepted; after re-enable, port1 empty_o=1 until the next push.
REQ-035 SHALL cover push plus pop at full: full FIFO, push 0xAA and pop on all ports in one cycle -> one entry removed, 0xAA not stored, usage_o=7.
REQ-036 SHALL cover fall-through with the macro defined: empty FIFO, push 0x5 with pop_i[0]=1 -> data_o[0]=0x5 and empty_o[0]=0 in the same cycle; next cycle cnt[0]=0 and cnt[1]=1.

Source files
------------

// File: rtl/mp_bcast_fifo_if.sv
// Bundle of write-side and per-port read-side signals for mp_bcast_fifo.
// The master drives push/pop/enables; the slave (the FIFO) drives status and data.
interface mp_bcast_fifo_if #(
  parameter int NrReadPort = 2,
  parameter int DataWidth  = 32,
  parameter int Depth      = 8
);
  localparam int UsageW = $clog2(Depth + 1);

  logic                                 flush_i;
  logic [DataWidth-1:0]                 data_i;
  logic                                 push_i;
  logic                                 full_o;
  logic                                 almost_full_o;
  logic [UsageW-1:0]                    usage_o;
  logic [NrReadPort-1:0]                port_en_i;
  logic [NrReadPort-1:0]                pop_i;
  logic [NrReadPort-1:0]                empty_o;
  logic [NrReadPort-1:0][DataWidth-1:0] data_o;

  modport master (
    output flush_i, data_i, push_i, port_en_i, pop_i,
    input  full_o, almost_full_o, usage_o, empty_o, data_o
  );

  modport slave (
    input  flush_i, data_i, push_i, port_en_i, pop_i,
    output full_o, almost_full_o, usage_o, empty_o, data_o
  );
endinterface

// File: rtl/mp_bcast_fifo.sv
// Broadcast FIFO: one writer, NrReadPort independent readers each seeing every entry.
// Define MP_BCAST_FIFO_FALL_THROUGH_EN to let a push reach an empty enabled port in the same cycle.
module mp_bcast_fifo #(
  parameter int NrReadPort       = 2,
  parameter int DataWidth        = 32,
  parameter int Depth            = 8,
  parameter int AlmostFullThresh = Depth - 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mp_bcast_fifo_if.slave bus
);
  localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int UsageW = $clog2(Depth + 1);
`ifdef MP_BCAST_FIFO_FALL_THROUGH_EN
  localparam bit FallThrough = 1'b1;
`else
  localparam bit FallThrough = 1'b0;
`endif

  typedef logic [PtrW-1:0]   ptr_t;
  typedef logic [UsageW-1:0] cnt_t;

  ptr_t                 wp_q, wp_d;
  ptr_t                 rp_q  [NrReadPort];
  ptr_t                 rp_d  [NrReadPort];
  cnt_t                 cnt_q [NrReadPort];
  cnt_t                 cnt_d [NrReadPort];
  logic [DataWidth-1:0] mem_q [Depth];

  cnt_t                                 usage;
  logic                                 push_acc;
  logic [NrReadPort-1:0]                ft;
  logic [NrReadPort-1:0]                pop_acc;
  logic [NrReadPort-1:0]                empty;
  logic [NrReadPort-1:0][DataWidth-1:0] head;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Occupancy is governed by the slowest enabled reader; disabled readers are ignored.
  always_comb begin
    usage = '0;
    for (int i = 0; i < NrReadPort; i++) begin
      if (bus.port_en_i[i] && (cnt_q[i] > usage)) usage = cnt_q[i];
    end
  end

  assign bus.usage_o       = usage;
  assign bus.full_o        = (usage == cnt_t'(Depth));
  assign bus.almost_full_o = (int'(usage) >= AlmostFullThresh);
  assign bus.empty_o       = empty;
  assign bus.data_o        = head;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    push_acc = bus.push_i && !bus.full_o;
    wp_d     = push_acc ? ptr_inc(wp_q) : wp_q;
    ft       = '0;
    pop_acc  = '0;
    empty    = '0;
    head     = '0;
    for (int i = 0; i < NrReadPort; i++) begin
      ft[i]      = FallThrough && bus.port_en_i[i] && (cnt_q[i] == '0) && push_acc;
      empty[i]   = ((cnt_q[i] == '0) || !bus.port_en_i[i]) && !ft[i];
      head[i]    = ft[i] ? bus.data_i : mem_q[rp_q[i]];
      pop_acc[i] = bus.pop_i[i] && bus.port_en_i[i] && !empty[i];
      if (!bus.port_en_i[i]) begin
        // A disabled port tracks the writer so it re-enters with nothing pending.
        rp_d[i]  = wp_d;
        cnt_d[i] = '0;
      end else begin
        rp_d[i]  = pop_acc[i] ? ptr_inc(rp_q[i]) : rp_q[i];
        cnt_d[i] = cnt_q[i] + cnt_t'(push_acc) - cnt_t'(pop_acc[i]);
      end
    end
    if (bus.flush_i) begin
      wp_d = '0;
      for (int i = 0; i < NrReadPort; i++) begin
        rp_d[i]  = '0;
        cnt_d[i] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      for (int i = 0; i < NrReadPort; i++) begin
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wp_q] <= bus.data_i;
  end
endmodule
